multicycle_alu: RTL and testbench

- Parametrised successor to the datapath ALU. Adds configurable width, a registered start/busy/done handshake, an iterative shift-add multiplier with configurable bits-per-cycle, logic operations and a full status-flag set.
- Sits between the register file read ports and the writeback mux.
- The control FSM launches one operation per `start`, stalls while `busy` is high, and captures `aluOut` when `done` pulses.

---
 rtl/multicycle_alu.sv | 171 +++++++++++++++++
 tb/tb_multicycle_alu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: single-cycle ADD/SUB/CMP/logic ops plus an iterative shift-add multiplier,
// start/busy/done handshake and zero/carry/sticky-compare status flags.
`default_nettype none

module multicycle_alu #(
  parameter int WIDTH      = 16,
  parameter int MUL_STEP   = 1,
  parameter int SIGNED_CMP = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flagClr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] aluOut,
  output logic             zeroFlag,
  output logic             carryFlag,
  output logic             ltFlag,
  output logic             eqFlag
);

  localparam int c_STEPS = (MUL_STEP > 0) ? WIDTH / MUL_STEP : 1;
  localparam int c_CW    = (c_STEPS > 1) ? $clog2(c_STEPS) : 1;

  localparam logic [2:0] c_OP_ADD   = 3'b000;
  localparam logic [2:0] c_OP_SUB   = 3'b001;
  localparam logic [2:0] c_OP_MUL   = 3'b010;
  localparam logic [2:0] c_OP_CMP   = 3'b011;
  localparam logic [2:0] c_OP_AND   = 3'b100;
  localparam logic [2:0] c_OP_OR    = 3'b101;
  localparam logic [2:0] c_OP_XOR   = 3'b110;
  localparam logic [2:0] c_OP_PASSB = 3'b111;

  generate
    if (WIDTH < 4 || MUL_STEP < 1 || (WIDTH % MUL_STEP) != 0) begin : g_bad_param
      $error("multicycle_alu: WIDTH must be >= 4 and divisible by MUL_STEP");
    end
  endgenerate

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [c_CW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;
  logic             r_carry;
  logic             r_lt;
  logic             r_eq;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;
  logic             w_ovf;
  logic             w_lt;
  logic [WIDTH-1:0] w_res;
  logic             w_carry;
  logic [WIDTH-1:0] w_pp;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;

  assign w_add = {1'b0, srcA} + {1'b0, srcB};
  assign w_sub = {1'b0, srcA} + {1'b0, ~srcB} + {{WIDTH{1'b0}}, 1'b1};
  // Signed less-than stays correct when the difference overflows.
  assign w_ovf = (srcA[WIDTH-1] ^ srcB[WIDTH-1]) & (w_sub[WIDTH-1] ^ srcA[WIDTH-1]);
  assign w_lt  = (SIGNED_CMP != 0) ? (w_sub[WIDTH-1] ^ w_ovf) : ~w_sub[WIDTH];

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (aluOp)
      c_OP_ADD:           begin w_res = w_add[WIDTH-1:0]; w_carry = w_add[WIDTH]; end
      c_OP_SUB, c_OP_CMP: begin w_res = w_sub[WIDTH-1:0]; w_carry = w_sub[WIDTH]; end
      c_OP_AND:           w_res = srcA & srcB;
      c_OP_OR:            w_res = srcA | srcB;
      c_OP_XOR:           w_res = srcA ^ srcB;
      c_OP_PASSB:         w_res = srcB;
      default:            w_res = '0;
    endcase
  end

  always_comb begin
    w_pp = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (r_mplier[k]) w_pp = w_pp + (r_mcand << k);
    end
  end

  assign w_acc_next = r_acc + w_pp;
  assign w_last     = (r_cnt == c_CW'(c_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_out    <= '0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // A CMP completing at this edge overrides the clear below.
      if (flagClr) begin
        r_lt <= 1'b0;
        r_eq <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (aluOp == c_OP_MUL) begin
              r_mcand  <= srcA;
              r_mplier <= srcB;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_busy   <= 1'b1;
              r_state  <= S_MUL;
            end else begin
              r_out   <= w_res;
              r_zero  <= (w_res == '0);
              r_carry <= w_carry;
              r_done  <= 1'b1;
              if (aluOp == c_OP_CMP) begin
                r_lt <= w_lt;
                r_eq <= (w_sub[WIDTH-1:0] == '0);
              end
            end
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << MUL_STEP;
          r_mplier <= r_mplier >> MUL_STEP;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_out   <= w_acc_next;
            r_zero  <= (w_acc_next == '0);
            r_carry <= 1'b0;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign aluOut    = r_out;
  assign zeroFlag  = r_zero;
  assign carryFlag = r_carry;
  assign ltFlag    = r_lt;
  assign eqFlag    = r_eq;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: table vectors, handshake corner sequences and random ops against a
// plain-arithmetic reference model, on a bit-serial signed instance and a 4-bit-step unsigned one.
`default_nettype none

module tb_multicycle_alu;
  localparam int W = 16;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, CMP = 3'd3;
  localparam logic [2:0] AND = 3'd4, OR = 3'd5, XOR = 3'd6, PASSB = 3'd7;

  logic clk = 1'b0, resetN = 1'b0, startA = 1'b0, startB = 1'b0, flagClr = 1'b0;
  logic [2:0] aluOp = '0;
  logic [W-1:0] srcA = '0, srcB = '0;
  logic busyA, doneA, zA, cA, ltA, eqA, busyB, doneB, zB, cB, ltB, eqB;
  logic [W-1:0] outA, outB;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W), .MUL_STEP(1), .SIGNED_CMP(1)) dutA (
    .clk(clk), .resetN(resetN), .start(startA), .aluOp(aluOp), .srcA(srcA), .srcB(srcB),
    .flagClr(flagClr), .busy(busyA), .done(doneA), .aluOut(outA), .zeroFlag(zA),
    .carryFlag(cA), .ltFlag(ltA), .eqFlag(eqA));

  multicycle_alu #(.WIDTH(W), .MUL_STEP(4), .SIGNED_CMP(0)) dutB (
    .clk(clk), .resetN(resetN), .start(startB), .aluOp(aluOp), .srcA(srcA), .srcB(srcB),
    .flagClr(flagClr), .busy(busyB), .done(doneB), .aluOut(outB), .zeroFlag(zB),
    .carryFlag(cB), .ltFlag(ltB), .eqFlag(eqB));

  int sel = 0;
  logic o_busy, o_done, o_z, o_c, o_lt, o_eq;
  logic [W-1:0] o_out;
  always_comb begin
    if (sel == 0) {o_busy, o_done, o_z, o_c, o_lt, o_eq, o_out} = {busyA, doneA, zA, cA, ltA, eqA, outA};
    else          {o_busy, o_done, o_z, o_c, o_lt, o_eq, o_out} = {busyB, doneB, zB, cB, ltB, eqB, outB};
  end

  int checks = 0, failures = 0;
  logic mlt [2];
  logic meq [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, t=%0t)", nm, act, exp, sel, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  task automatic model(input int s, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic z, output logic c,
                       output logic lt, output logic eq);
    longint ua = longint'(a), ub = longint'(b), m = longint'(1) << W, t;
    c = 1'b0;
    t = 0;
    case (op)
      ADD:      begin t = ua + ub; c = (t >= m); end
      SUB, CMP: begin t = ua + m - ub; c = (ua >= ub); end
      MUL:      t = ua * ub;
      AND:      t = ua & ub;
      OR:       t = ua | ub;
      XOR:      t = ua ^ ub;
      default:  t = ub;
    endcase
    r  = W'(t % m);
    z  = (r == '0);
    lt = (s == 0) ? ($signed(a) < $signed(b)) : (ua < ub);
    eq = (a == b);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic clr, output int edge_k, output int busy_n);
    @(negedge clk);
    if (sel == 0) startA = 1'b1; else startB = 1'b1;
    aluOp = op; srcA = a; srcB = b; flagClr = clr;
    @(posedge clk); #1;
    startA = 1'b0; startB = 1'b0; flagClr = 1'b0;
    aluOp = 3'($urandom); srcA = W'($urandom); srcB = W'($urandom);
    edge_k = 0; busy_n = 0;
    while (!o_done && edge_k < 40) begin
      if (o_busy) busy_n++;
      @(posedge clk); #1;
      edge_k++;
    end
    if (!o_done) edge_k = -1;
  endtask

  task automatic check_op(input string nm, input int s, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic clr, input logic [W-1:0] er,
                          input logic ez, input logic ec, input logic elt, input logic eeq, input int ee);
    int k, bn;
    sel = s;
    run_op(op, a, b, clr, k, bn);
    chk({nm, " done_edge"}, k, ee);
    chk({nm, " busy_cycles"}, bn, ee);
    chk({nm, " busy_at_done"}, {31'd0, o_busy}, 0);
    chk({nm, " aluOut"}, {16'd0, o_out}, {16'd0, er});
    chk({nm, " zero"}, {31'd0, o_z}, {31'd0, ez});
    chk({nm, " carry"}, {31'd0, o_c}, {31'd0, ec});
    chk({nm, " lt"}, {31'd0, o_lt}, {31'd0, elt});
    chk({nm, " eq"}, {31'd0, o_eq}, {31'd0, eeq});
    @(posedge clk); #1;
    chk({nm, " done_pulse_width"}, {31'd0, o_done}, 0);
  endtask

  task automatic flag_clear_cycle();
    @(negedge clk); flagClr = 1'b1;
    @(posedge clk); #1; flagClr = 1'b0;
  endtask

  task automatic rand_op(input int s);
    logic [2:0] op;
    logic [W-1:0] a, b, r;
    logic z, c, lt, eq, clr;
    int pick;
    op = 3'($urandom_range(0, 7));
    a = W'($urandom); b = W'($urandom);
    pick = $urandom_range(0, 7);
    if (pick == 0) b = a;
    if (pick == 1) a = 16'h8000;
    if (pick == 2) b = 16'hFFFF;
    if (pick == 3) a = 16'h0000;
    clr = ($urandom_range(0, 3) == 0);
    model(s, op, a, b, r, z, c, lt, eq);
    if (op == CMP) begin
      mlt[s] = lt; meq[s] = eq;
    end else if (clr) begin
      mlt[s] = 1'b0; meq[s] = 1'b0;
    end
    check_op("rand", s, op, a, b, clr, r, z, c, mlt[s], meq[s], (op == MUL) ? ((s == 0) ? 16 : 4) : 0);
  endtask

  typedef struct {
    int s; logic [2:0] op; logic [W-1:0] a, b, r; logic z, c, lt, eq; int e;
  } vec_t;
  vec_t vt [17];

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int k, bn, seen;
    vt[0]  = '{0, ADD,   16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vt[1]  = '{0, MUL,   16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    vt[2]  = '{0, MUL,   16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16};
    vt[3]  = '{0, CMP,   16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    vt[4]  = '{0, ADD,   16'h0001, 16'h0002, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vt[5]  = '{0, CMP,   16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 0};
    vt[6]  = '{0, AND,   16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vt[7]  = '{0, OR,    16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vt[8]  = '{0, XOR,   16'hAAAA, 16'hAAAA, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 0};
    vt[9]  = '{0, PASSB, 16'h1234, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vt[10] = '{0, SUB,   16'h0003, 16'h0005, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1, 0};
    vt[11] = '{0, CMP,   16'h7FFF, 16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vt[12] = '{0, SUB,   16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vt[13] = '{1, MUL,   16'h0123, 16'h0045, 16'h4E6F, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vt[14] = '{1, CMP,   16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 0};
    vt[15] = '{1, CMP,   16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 0};
    vt[16] = '{1, MUL,   16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 4};

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s; #0;
      chk("reset busy", {31'd0, o_busy}, 0);
      chk("reset done", {31'd0, o_done}, 0);
      chk("reset aluOut", {16'd0, o_out}, 0);
      chk("reset flags", {28'd0, o_z, o_c, o_lt, o_eq}, 0);
    end
    sel = 0;
    @(negedge clk); resetN = 1'b1;

    for (int i = 0; i < 17; i++)
      check_op($sformatf("vec%0d", i), vt[i].s, vt[i].op, vt[i].a, vt[i].b, 1'b0,
               vt[i].r, vt[i].z, vt[i].c, vt[i].lt, vt[i].eq, vt[i].e);

    // start during busy is dropped; start in the done cycle issues back-to-back
    sel = 0;
    @(negedge clk); startA = 1'b1; aluOp = MUL; srcA = 16'h0003; srcB = 16'h0007;
    @(posedge clk); #1; startA = 1'b0;
    k = 0;
    repeat (3) begin @(posedge clk); #1; k++; end
    @(negedge clk); startA = 1'b1; aluOp = ADD; srcA = 16'h0001; srcB = 16'h0001;
    @(posedge clk); #1; startA = 1'b0; k++;
    while (!doneA && k < 40) begin @(posedge clk); #1; k++; end
    chk("ignored_start done_edge", k, 16);
    chk("ignored_start aluOut", {16'd0, outA}, 32'h15);
    startA = 1'b1; aluOp = ADD; srcA = 16'h0010; srcB = 16'h0020;
    @(posedge clk); #1; startA = 1'b0;
    chk("back2back done", {31'd0, doneA}, 1);
    chk("back2back aluOut", {16'd0, outA}, 32'h30);
    chk("back2back busy", {31'd0, busyA}, 0);
    @(posedge clk); #1;
    chk("back2back done_width", {31'd0, doneA}, 0);

    // flagClr colliding with a completing CMP, then alone
    check_op("cmp_clr", 0, CMP, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    flag_clear_cycle();
    chk("clr lt", {31'd0, ltA}, 0);
    chk("clr eq", {31'd0, eqA}, 0);
    chk("clr carry_kept0", {31'd0, cA}, 0);
    check_op("add_c", 0, ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    flag_clear_cycle();
    chk("clr carry_kept1", {31'd0, cA}, 1);
    chk("clr zero_kept1", {31'd0, zA}, 1);

    // reset asserted in the 5th busy cycle of a MUL
    @(negedge clk); startA = 1'b1; aluOp = MUL; srcA = 16'h0123; srcB = 16'h0045;
    @(posedge clk); #1; startA = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midreset busy_before", {31'd0, busyA}, 1);
    resetN = 1'b0;
    @(posedge clk); #1; resetN = 1'b1;
    chk("midreset busy", {31'd0, busyA}, 0);
    chk("midreset done", {31'd0, doneA}, 0);
    chk("midreset aluOut", {16'd0, outA}, 0);
    seen = 0;
    repeat (25) begin @(posedge clk); #1; if (doneA) seen++; end
    chk("midreset no_done", seen, 0);
    check_op("after_reset", 0, ADD, 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    flag_clear_cycle();
    mlt[0] = 1'b0; meq[0] = 1'b0; mlt[1] = 1'b0; meq[1] = 1'b0;
    for (int i = 0; i < 40; i++) rand_op(0);
    for (int i = 0; i < 20; i++) rand_op(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
